pool_window_gen: RTL and testbench

- Streaming front end for the 2x2 max-pool stage: accepts a raster-order pixel stream (one N-bit pixel per transfer) from the conv layer.
- Buffers one image row and emits each non-overlapping 2x2 window as a flattened 4N-bit block, in the exact packing the maxpool2x2 block consumes.
- Sits between the conv1/conv2 output stream and maxpool2x2; one block per pooled output pixel, raster order.

---
 rtl/pool_pkg.sv | 31 +++
 rtl/pool_line_buf.sv | 33 +++
 rtl/pool_window_gen.sv | 109 ++++++++++
 tb/tb_pool_window_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling path: block lane layout, default geometries, lane helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pool_pkg;

    // Lane positions of the four window pixels inside a flattened 4N-bit block.
    localparam int LANE_TL = 3;
    localparam int LANE_TR = 2;
    localparam int LANE_BL = 1;
    localparam int LANE_BR = 0;

    // Default stream geometries of the two conv stages feeding the poolers.
    localparam int CONV1_N     = 16;
    localparam int CONV1_IMG_W = 28;
    localparam int CONV1_IMG_H = 28;
    localparam int CONV2_N     = 16;
    localparam int CONV2_IMG_W = 10;
    localparam int CONV2_IMG_H = 10;

    // Widest pixel the lane helper handles.
    localparam int LANE_MAX_W = 32;

    // Extract lane 'lane' of an n-bit-per-lane block (block zero-extended to 4*LANE_MAX_W).
    function automatic logic [LANE_MAX_W-1:0] lane_slice(input logic [4*LANE_MAX_W-1:0] blk,
                                                        input int lane, input int n);
        logic [4*LANE_MAX_W-1:0] mask;
        mask = (128'(1) << n) - 128'(1);
        return LANE_MAX_W'((blk >> (lane * n)) & mask);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store with a single write port and two combinational taps at raddr-1 and raddr.
// Latency: write visible on the cycle after we; reads are combinational.
// Backpressure: none; the caller gates we.
module pool_line_buf #(
    parameter int N     = 16,
    parameter int DEPTH = 28,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata_left,
    output logic [N-1:0]  rdata_right
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] left_addr;

    // Row storage; contents are never reset, every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // raddr is always odd when the taps are used, so raddr-1 never wraps.
    assign left_addr   = raddr - AW'(1);
    assign rdata_left  = mem[left_addr];
    assign rdata_right = mem[raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows packed as {TL,TR,BL,BR}.
// Latency: block registered 1 cycle after its bottom-right pixel is accepted.
// Backpressure: pix_ready = !blk_valid || blk_ready; a pending untaken block stalls all input.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int N     = CONV1_N,
    parameter int IMG_W = CONV1_IMG_W,
    parameter int IMG_H = CONV1_IMG_H
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_valid,
    output logic           pix_ready,
    input  logic [N-1:0]   pix_data,
    output logic           blk_valid,
    input  logic           blk_ready,
    output logic [4*N-1:0] blk_data,
    output logic           blk_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    // Windows only tile the frame exactly for even dimensions.
    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_geometry
        $fatal(1, "pool_window_gen: IMG_W and IMG_H must be even and >= 2");
    end

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [N-1:0]   bl_reg;
    logic [N-1:0]   top_left;
    logic [N-1:0]   top_right;
    logic [4*N-1:0] blk_next;
    logic           pix_acc;
    logic           row_odd;
    logic           col_odd;
    logic           blk_load;

    assign pix_ready = !blk_valid || blk_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign row_odd   = row[0];
    assign col_odd   = col[0];
    assign blk_load  = pix_acc && row_odd && col_odd;

    pool_line_buf #(
        .N     (N),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buf (
        .clk         (clk),
        .we          (pix_acc && !row_odd),
        .waddr       (col),
        .wdata       (pix_data),
        .raddr       (col),
        .rdata_left  (top_left),
        .rdata_right (top_right)
    );

    // Pack the window being completed by the current pixel.
    always_comb begin
        blk_next = '0;
        blk_next[LANE_TL*N +: N] = top_left;
        blk_next[LANE_TR*N +: N] = top_right;
        blk_next[LANE_BL*N +: N] = bl_reg;
        blk_next[LANE_BR*N +: N] = pix_data;
    end

    // Raster position; advances only on accepted pixels and wraps frame to frame without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_acc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Bottom-left pixel of the window, captured on odd rows at even columns.
    always_ff @(posedge clk) begin
        if (pix_acc && row_odd && !col_odd) begin
            bl_reg <= pix_data;
        end
    end

    // Output register: loads on a completed window, holds while stalled, clears after a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_last  <= 1'b0;
        end else if (blk_load) begin
            blk_valid <= 1'b1;
            blk_data  <= blk_next;
            blk_last  <= (row == ROW_MAX) && (col == COL_MAX);
        end else if (blk_ready) begin
            blk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
`timescale 1ns/1ps
module tb_pool_window_gen;
    import pool_pkg::*;

    localparam int N  = 16;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 28;
    localparam int LH = 28;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [15:0] mx;
        logic [31:0] cyc;
        logic        lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    // Small (4x4) instance
    logic        rst_n_s, pix_valid_s, pix_ready_s, blk_valid_s, blk_ready_s, blk_last_s;
    logic [15:0] pix_data_s;
    logic [63:0] blk_data_s;

    // Default (28x28) instance
    logic        rst_n_l, pix_valid_l, pix_ready_l, blk_valid_l, blk_ready_l, blk_last_l;
    logic [15:0] pix_data_l;
    logic [63:0] blk_data_l;

    pool_window_gen #(.N(N), .IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .pix_valid(pix_valid_s), .pix_ready(pix_ready_s),
        .pix_data(pix_data_s), .blk_valid(blk_valid_s), .blk_ready(blk_ready_s),
        .blk_data(blk_data_s), .blk_last(blk_last_s)
    );

    pool_window_gen #(.N(N), .IMG_W(LW), .IMG_H(LH)) dut_l (
        .clk(clk), .rst_n(rst_n_l), .pix_valid(pix_valid_l), .pix_ready(pix_ready_l),
        .pix_data(pix_data_l), .blk_valid(blk_valid_l), .blk_ready(blk_ready_l),
        .blk_data(blk_data_l), .blk_last(blk_last_l)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- reference models: frame images indexed by raster position ----------------
    logic [15:0] img_s [SW*SH];
    logic [15:0] img_l [LW*LH];
    int   pos_s = 0;
    int   pos_l = 0;
    exp_t q_s[$];
    exp_t q_l[$];
    logic lat_mode = 1'b0;
    logic rdy_mode = 1'b0;

    function automatic logic [15:0] max4(input logic [15:0] a, b, c, d);
        logic [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_s(input logic [15:0] d);
        int r, c;
        exp_t e;
        img_s[pos_s] = d;
        r = pos_s / SW;
        c = pos_s % SW;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e      = '0;
            e.data = {img_s[pos_s-SW-1], img_s[pos_s-SW], img_s[pos_s-1], d};
            e.last = (pos_s == SW*SH-1);
            e.cyc  = 32'(cyc + 1);
            e.lat  = lat_mode;
            q_s.push_back(e);
        end
        pos_s = (pos_s + 1) % (SW*SH);
    endtask

    task automatic model_l(input logic [15:0] d);
        int r, c;
        exp_t e;
        img_l[pos_l] = d;
        r = pos_l / LW;
        c = pos_l % LW;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e      = '0;
            e.data = {img_l[pos_l-LW-1], img_l[pos_l-LW], img_l[pos_l-1], d};
            e.mx   = max4(img_l[pos_l-LW-1], img_l[pos_l-LW], img_l[pos_l-1], d);
            e.last = (pos_l == LW*LH-1);
            q_l.push_back(e);
        end
        pos_l = (pos_l + 1) % (LW*LH);
    endtask

    // ---------------- monitors ----------------
    int got_s = 0;
    int got_l = 0;
    int last_l = 0;

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (blk_valid_s === 1'b1 && blk_ready_s === 1'b1) begin
            if (q_s.size() == 0) begin
                flag("blk_s_expected");
            end else begin
                e = q_s.pop_front();
                chk("blk_data_s", blk_data_s, e.data);
                chk("blk_last_s", 64'(blk_last_s), 64'(e.last));
                if (e.lat) chk("blk_latency_s", 64'(cyc), 64'(e.cyc));
            end
            got_s++;
        end
    end

    always @(negedge clk) begin : mon_l
        exp_t e;
        logic [15:0] v, mx;
        if (blk_valid_l === 1'b1 && blk_ready_l === 1'b1) begin
            if (q_l.size() == 0) begin
                flag("blk_l_expected");
            end else begin
                e  = q_l.pop_front();
                mx = '0;
                for (int k = 0; k < 4; k++) begin
                    v = 16'(lane_slice(128'(blk_data_l), k, N));
                    if (v > mx) mx = v;
                end
                chk("blk_data_l", blk_data_l, e.data);
                chk("blk_last_l", 64'(blk_last_l), 64'(e.last));
                chk("pooled_max_l", 64'(mx), 64'(e.mx));
            end
            got_l++;
            if (blk_last_l) last_l++;
        end
    end

    // ---------------- small-instance driver tasks ----------------
    task automatic cycle_s(input logic v, input logic [15:0] d, input logic br, output logic acc);
        pix_valid_s = v;
        pix_data_s  = d;
        blk_ready_s = br;
        @(negedge clk);
        acc = v && pix_ready_s;
        if (rdy_mode) chk("pix_ready_s_const", 64'(pix_ready_s), 64'd1);
        if (acc) model_s(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send_s(input logic [15:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle_s(1'b1, d, 1'b1, acc);
            tries++;
        end
        if (!acc) flag("send_s_accept");
        pix_valid_s = 1'b0;
    endtask

    task automatic idle_s(input int n);
        logic acc;
        repeat (n) cycle_s(1'b0, 16'h0, 1'b1, acc);
    endtask

    task automatic reset_s();
        rst_n_s     = 1'b0;
        pix_valid_s = 1'b0;
        blk_ready_s = 1'b0;
        @(posedge clk);
        #1;
        rst_n_s = 1'b1;
        q_s.delete();
        pos_s = 0;
    endtask

    task automatic check_reset_state_s(input string tag);
        chk({tag, "_blk_valid"}, 64'(blk_valid_s), 64'd0);
        chk({tag, "_blk_data"},  blk_data_s,       64'd0);
        chk({tag, "_blk_last"},  64'(blk_last_s),  64'd0);
        chk({tag, "_pix_ready"}, 64'(pix_ready_s), 64'd1);
    endtask

    // ---------------- large-instance random driver ----------------
    logic done_l = 1'b0;

    initial begin : drv_l
        int   sent, budget;
        logic acc;
        rst_n_l = 1'b0; pix_valid_l = 1'b0; blk_ready_l = 1'b0; pix_data_l = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_l = 1'b1;
        sent   = 0;
        budget = 0;
        while (sent < 2*LW*LH && budget < 20000) begin
            if (!pix_valid_l && $urandom_range(0, 3) != 0) begin
                pix_valid_l = 1'b1;
                pix_data_l  = 16'($urandom);
            end
            blk_ready_l = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = pix_valid_l && pix_ready_l;
            if (acc) begin
                model_l(pix_data_l);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) pix_valid_l = 1'b0;
            budget++;
        end
        if (sent < 2*LW*LH) flag("large_stream_progress");
        pix_valid_l = 1'b0;
        blk_ready_l = 1'b1;
        budget = 0;
        while (q_l.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        done_l = 1'b1;
    end

    // ---------------- main sequence (small instance) ----------------
    initial begin : main
        logic acc;
        rst_n_s = 1'b0; pix_valid_s = 1'b0; pix_data_s = '0; blk_ready_s = 1'b0;
        @(posedge clk);
        #1;
        reset_s();
        check_reset_state_s("reset");

        // Continuous 4x4 frame, downstream always ready: latency and pix_ready checked.
        lat_mode = 1'b1;
        rdy_mode = 1'b1;
        for (int i = 0; i < 16; i++) send_s(16'(i));
        idle_s(2);
        lat_mode = 1'b0;
        rdy_mode = 1'b0;

        // Stall on the first block for 5 cycles.
        for (int i = 0; i < 6; i++) send_s(16'(i));
        repeat (5) begin
            cycle_s(1'b1, 16'd6, 1'b0, acc);
            chk("stall_accept",    64'(acc),         64'd0);
            chk("stall_blk_valid", 64'(blk_valid_s), 64'd1);
            chk("stall_blk_data",  blk_data_s,       64'h0000_0001_0004_0005);
        end
        for (int i = 6; i < 16; i++) send_s(16'(i));
        idle_s(2);

        // Two back-to-back frames.
        for (int i = 0; i < 16; i++) send_s(16'(i));
        for (int i = 100; i < 116; i++) send_s(16'(i));
        idle_s(2);

        // Reset while the first block of a frame is pending and untaken.
        for (int i = 0; i < 6; i++) send_s(16'(i));
        reset_s();
        check_reset_state_s("midframe_reset");
        for (int i = 0; i < 16; i++) send_s(16'(i));
        idle_s(2);

        wait (done_l);

        chk("blocks_small",     64'(got_s),      64'd20);
        chk("queue_small_left", 64'(q_s.size()), 64'd0);
        chk("blocks_large",     64'(got_l),      64'(2 * (LW/2) * (LH/2)));
        chk("frames_large",     64'(last_l),     64'd2);
        chk("queue_large_left", 64'(q_l.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
